expr_eval_arbiter: RTL
======================

EXPR_EVAL_ARBITER -- requirements
Module: expr_eval_arbiter

Interface
REQ-001 SHALL have parameter NUM_LANES, default 3, number of requesting lanes (range 2..4).
REQ-002 SHALL have parameter RES_W, default 10, result width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, NUM_LANES bits: per-lane evaluation request, level.
REQ-006 SHALL have port req_exp, input, 12*NUM_LANES bits: lane i expression at [12i+11:12i].
- Expression format: [11:8] operand A; [7:4] opcode (A add, B sub, C mul, D div); [3:0] operand B.
REQ-007 SHALL have port gnt, output, NUM_LANES bits: one-hot grant, single-cycle pulse.
REQ-008 SHALL have port done, output, 1 bit: result-valid, single-cycle pulse.
REQ-009 SHALL have port done_lane, output, 2 bits: index of the lane whose result is presented.
REQ-010 SHALL have port result, output, RES_W bits: evaluated value, held until the next done.
REQ-011 SHALL have port err, output, 1 bit: qualifies done; divide-by-zero or invalid opcode.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, EXEC, DIV, DONE.
- IDLE->LOAD when any req is high.
- LOAD->EXEC for add, sub, mul, and for invalid opcodes.
- LOAD->DIV for div.
- EXEC->DONE.
- DIV->DONE after 4 iterations.
- DONE->IDLE.
REQ-014 SHALL in LOAD pulse gnt for exactly one cycle for the winning lane and capture that lane's req_exp.
REQ-015 SHALL arbitrate round-robin: the search starts at the lane after the last granted lane, and lane 0 is searched first after reset.
REQ-016 SHALL ignore req while busy; a requester holds req until it sees gnt and may withdraw without side effect before gnt.
REQ-017 SHALL compute arithmetic zero-extended to RES_W bits:
- add: A+B;
- sub: (A-B) mod 2^RES_W, so 3-5 = 0x3FE;
- mul: A*B, maximum 225;
- div: floor(A/B).
REQ-018 SHALL assert done in DONE, where the latency from the gnt cycle is:
- 2 cycles for add, sub, mul and invalid opcodes;
- 6 cycles for div.
REQ-019 SHALL on divide-by-zero return result all-ones with err=1.
REQ-020 SHALL on an invalid opcode (0-9, E, F) return result 0 with err=1.
REQ-021 SHALL allow a lane re-requesting in its own DONE cycle to be considered in the next IDLE cycle, subject to round-robin order.
REQ-022 SHALL treat an expression of 0x000 as invalid (err=1), so that empty lanes never produce a valid answer.

Reset
REQ-023 SHALL on rst reach IDLE and drive gnt=0, done=0, done_lane=0, result=0, err=0 and busy=0.
REQ-024 SHALL on rst reset the round-robin pointer so that lane 0 wins next.
REQ-025 SHALL on rst asserted mid-operation (any state) abort the operation, emit no done, and lose the captured expression.

Configuration
REQ-026 SHALL support macro EXPR_EVAL_DIV_EN.
- Defined: division is evaluated through the DIV state.
- Undefined: opcode D is an invalid opcode per REQ-020, the DIV state and divider logic are absent, and all latencies are 2 cycles.

Structure
REQ-027 SHALL take the following from shared package calc_pkg:
- opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
- EXP_W=12;
- the expression field positions;
- the FSM state typedef.
REQ-028 SHALL instantiate one sub-module, seq_divider: a 4-bit restoring divider with start/done handshake and 1 iteration per cycle, present only under EXPR_EVAL_DIV_EN.

Verification
REQ-029 Bench SHALL check: req=001, lane0 exp=0x7A5 -> gnt=001 at cycle N, done at N+2, result=12, err=0, done_lane=0.
REQ-030 Bench SHALL check: req=111 held, exps 0x3B5/0x4C6/0x9D2 -> grants in order lane0, lane1, lane2; results 0x3FE, 24, 4; the DIV done comes 6 cycles after its gnt.
REQ-031 Bench SHALL check: 0x8D0 with DIV enabled -> result=0x3FF, err=1; 0x000 -> result=0, err=1; 0x5F2 -> result=0, err=1.
REQ-032 Bench SHALL check: lane1 granted, then req=011 held -> next grant lane0, then lane1 (round-robin wrap).
REQ-033 Bench SHALL check: rst pulsed during cycle 3 of DIV -> no done; busy=0 immediately; next req=100 -> gnt=100 is the next grant.
REQ-034 Bench SHALL check: build without EXPR_EVAL_DIV_EN, 0x6D3 -> done 2 cycles after gnt, result=0, err=1.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: expression encoding, opcodes and FSM state type shared by the evaluator blocks.
package calc_pkg;

    localparam int EXP_W = 12;

    // Expression layout: {operand A, opcode, operand B}
    localparam int A_MSB  = 11;
    localparam int A_LSB  = 8;
    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;
    localparam int B_MSB  = 3;
    localparam int B_LSB  = 0;

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EXEC = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: 4-bit restoring divider, one quotient bit per cycle, four cycles after start_i.
// Only built when EXPR_EVAL_DIV_EN is defined.
`ifdef EXPR_EVAL_DIV_EN
module seq_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       done_o,
    output logic [3:0] quo_o
);
    logic [3:0] rem_q, quo_q, rem_d, quo_d;
    logic [2:0] cnt_q;
    logic       busy_q;
    logic [4:0] shifted;

    always_comb begin
        shifted = {rem_q, quo_q[3]};
        rem_d   = shifted[3:0];
        quo_d   = {quo_q[2:0], 1'b0};
        if (shifted >= {1'b0, b_i}) begin
            rem_d = 4'(shifted - {1'b0, b_i});
            quo_d = {quo_q[2:0], 1'b1};
        end
    end

    // done_o flags the final iteration; quo_o is the quotient that iteration produces.
    assign done_o = busy_q && (cnt_q == 3'd1);
    assign quo_o  = quo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            quo_q  <= a_i;
            cnt_q  <= 3'd4;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) busy_q <= 1'b0;
        end
    end
endmodule
`endif

// File: rtl/expr_eval_arbiter.sv
// expr_eval_arbiter: round-robin arbiter in front of a single 12-bit expression evaluator.
// Define EXPR_EVAL_DIV_EN to evaluate opcode D via seq_divider; otherwise D is an invalid opcode.
module expr_eval_arbiter
    import calc_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int RES_W     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES-1:0]       req,
    input  logic [EXP_W*NUM_LANES-1:0] req_exp,
    output logic [NUM_LANES-1:0]       gnt,
    output logic                       done,
    output logic [1:0]                 done_lane,
    output logic [RES_W-1:0]           result,
    output logic                       err,
    output logic                       busy,
    output state_t                     dbg_state
);
    state_t               state_q;
    logic [NUM_LANES-1:0] gnt_q, gnt_d;
    logic                 done_q, err_q, busy_q;
    logic [1:0]           lane_q, last_q, done_lane_q, win_idx, cand_l;
    logic [RES_W-1:0]     result_q, alu_res;
    logic [EXP_W-1:0]     exp_q, exp_d;
    logic                 win_valid, alu_err;
    logic [3:0]           op_a, op_code, op_b;
    int                   cand;

    assign op_a    = exp_q[A_MSB:A_LSB];
    assign op_code = exp_q[OP_MSB:OP_LSB];
    assign op_b    = exp_q[B_MSB:B_LSB];

    // Search starts one past the last granted lane, wrapping at NUM_LANES.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_l    = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_LANES) cand = cand - NUM_LANES;
            cand_l = 2'(cand);
            if (!win_valid && req[cand_l]) begin
                win_valid = 1'b1;
                win_idx   = cand_l;
            end
        end
        gnt_d = NUM_LANES'(1) << win_idx;
    end

    always_comb begin
        exp_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == 2'(i)) exp_d = req_exp[i*EXP_W +: EXP_W];
        end
    end

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_code)
            OP_ADD:  alu_res = RES_W'(op_a) + RES_W'(op_b);
            OP_SUB:  alu_res = RES_W'(op_a) - RES_W'(op_b);
            OP_MUL:  alu_res = RES_W'(8'(op_a) * 8'(op_b));
            default: alu_err = 1'b1;
        endcase
    end

`ifdef EXPR_EVAL_DIV_EN
    logic       start_q, div_done;
    logic [3:0] div_quo;

    seq_divider u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_q),
        .a_i     (op_a),
        .b_i     (op_b),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= 1'b0;
            done_lane_q <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            lane_q      <= '0;
            last_q      <= 2'(NUM_LANES - 1);
            exp_q       <= '0;
`ifdef EXPR_EVAL_DIV_EN
            start_q     <= 1'b0;
`endif
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
`ifdef EXPR_EVAL_DIV_EN
            start_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                        gnt_q   <= gnt_d;
                        lane_q  <= win_idx;
                        last_q  <= win_idx;
                    end
                end
                ST_LOAD: begin
                    exp_q   <= exp_d;
                    state_q <= ST_EXEC;
`ifdef EXPR_EVAL_DIV_EN
                    if (exp_d[OP_MSB:OP_LSB] == OP_DIV) begin
                        state_q <= ST_DIV;
                        start_q <= 1'b1;
                    end
`endif
                end
                ST_EXEC: begin
                    state_q     <= ST_DONE;
                    done_q      <= 1'b1;
                    done_lane_q <= lane_q;
                    result_q    <= alu_res;
                    err_q       <= alu_err;
                end
`ifdef EXPR_EVAL_DIV_EN
                ST_DIV: begin
                    if (div_done) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        done_lane_q <= lane_q;
                        err_q       <= (op_b == 4'd0);
                        result_q    <= (op_b == 4'd0) ? '1 : RES_W'(div_quo);
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign done_lane = done_lane_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
